// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : spi_slave -- SPI target oversampled in clk, AXI-Stream tx/rx ports.
//           Optional macro SPI_SLAVE_ECHO_EN: empty tx buffer re-sends last rx word.
// Rev     : 1.0
// ============================================================================
module spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs,
    input  logic                 sck,
    input  logic                 mosi,
    output logic                 miso,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [5:0]           width,
    input  logic [MAX_WIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [MAX_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 rx_overflow,
    output logic                 tx_underflow
);

    localparam logic [5:0] C_MAX_W = 6'(MAX_WIDTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sck_prev, r_cs_prev;
    logic [1:0]             r_state, w_state_nxt;
    logic [5:0]             r_width, r_bit_cnt;
    logic [MAX_WIDTH-1:0]   r_buf, r_tx_shift, r_rx_shift, r_m_data;
    logic                   r_buf_full, r_miso, r_m_valid, r_rx_overflow, r_tx_underflow;
    logic                   r_unf_pending;
    logic                   w_in_load, w_in_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    wire w_sck_s   = r_sck_sync[SYNC_STAGES-1];
    wire w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    wire w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    wire w_cs_fall = r_cs_prev & ~w_cs_s;
    wire w_cs_rise = ~r_cs_prev & w_cs_s;
    wire w_sck_edg = w_sck_s ^ r_sck_prev;
    wire w_lead    = w_sck_edg & (w_sck_s != cpol);
    wire w_trail   = w_sck_edg & (w_sck_s == cpol);
    wire w_sample  = cpha ? w_trail : w_lead;
    wire w_shift   = cpha ? w_lead : w_trail;

    wire [5:0] w_width_eff = ((width == 6'd0) || (width > C_MAX_W)) ? C_MAX_W : width;
    wire [5:0] w_shamt     = C_MAX_W - r_width;
    wire [5:0] w_cnt_inc   = r_bit_cnt + 6'd1;
    wire [MAX_WIDTH-1:0] w_rx_next = {r_rx_shift[MAX_WIDTH-2:0], w_mosi_s};
    wire w_word_done = w_in_shift & w_sample & (w_cnt_inc == r_width) & ~w_cs_rise;

`ifdef SPI_SLAVE_ECHO_EN
    logic [MAX_WIDTH-1:0] r_last_rx;
    wire  [MAX_WIDTH-1:0] w_empty_word = r_last_rx;
`else
    wire  [MAX_WIDTH-1:0] w_empty_word = '0;
`endif
    // Left-align the word so the next outgoing bit is always the register MSB.
    wire [MAX_WIDTH-1:0] w_load_word = (r_buf_full ? r_buf : w_empty_word) << w_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_word_done) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_cs_rise) w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_in_load  = (r_state == S_LOAD);
        w_in_shift = (r_state == S_SHIFT);
        miso       = (r_state == S_IDLE) ? 1'b0 : r_miso;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width        <= '0;
            r_bit_cnt      <= '0;
            r_buf          <= '0;
            r_buf_full     <= 1'b0;
            r_tx_shift     <= '0;
            r_rx_shift     <= '0;
            r_miso         <= 1'b0;
            r_m_data       <= '0;
            r_m_valid      <= 1'b0;
            r_rx_overflow  <= 1'b0;
            r_tx_underflow <= 1'b0;
            r_unf_pending  <= 1'b0;
`ifdef SPI_SLAVE_ECHO_EN
            r_last_rx      <= '0;
`endif
        end else begin
            r_rx_overflow  <= 1'b0;
            r_tx_underflow <= 1'b0;
            if (s_axis_tvalid && !r_buf_full) begin
                r_buf      <= s_axis_tdata;
                r_buf_full <= 1'b1;
            end
            if (r_m_valid && m_axis_tready) r_m_valid <= 1'b0;
            if ((r_state == S_IDLE) && w_cs_fall) r_width <= w_width_eff;
            if (w_in_load) begin
                r_buf_full    <= 1'b0;
                r_bit_cnt     <= '0;
                r_rx_shift    <= '0;
                r_unf_pending <= ~r_buf_full;
                if (cpha) begin
                    r_tx_shift <= w_load_word;
                end else begin
                    r_tx_shift <= {w_load_word[MAX_WIDTH-2:0], 1'b0};
                    r_miso     <= w_load_word[MAX_WIDTH-1];
                end
            end
            if (w_in_shift) begin
                // Underflow is flagged when the word really starts, so the
                // speculative reload after a frame's last word stays silent.
                if (w_lead && r_unf_pending) begin
                    r_tx_underflow <= 1'b1;
                    r_unf_pending  <= 1'b0;
                end
                if (w_shift && (cpha || (r_bit_cnt != 6'd0))) begin
                    r_miso     <= r_tx_shift[MAX_WIDTH-1];
                    r_tx_shift <= r_tx_shift << 1;
                end
                if (w_sample) begin
                    r_rx_shift <= w_rx_next;
                    r_bit_cnt  <= w_cnt_inc;
                end
                if (w_word_done) begin
                    if (!r_m_valid || m_axis_tready) begin
                        r_m_data  <= w_rx_next;
                        r_m_valid <= 1'b1;
                    end else begin
                        r_rx_overflow <= 1'b1;
                    end
`ifdef SPI_SLAVE_ECHO_EN
                    r_last_rx <= w_rx_next;
`endif
                end
            end
            if (w_cs_rise) begin
                r_miso        <= 1'b0;
                r_bit_cnt     <= '0;
                r_unf_pending <= 1'b0;
            end
        end
    end

    assign s_axis_tready = ~r_buf_full;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_valid;
    assign rx_overflow   = r_rx_overflow;
    assign tx_underflow  = r_tx_underflow;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave -- behavioural SPI master plus rx-beat scoreboard.
// Rev     : 1.0
// ============================================================================
module tb_spi_slave;

    localparam int HALF = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cs = 1'b1, sck = 1'b0, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic        miso;
    logic [5:0]  width = 6'd8;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready = 1'b1;
    logic        rx_overflow, tx_underflow;

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(2), .MAX_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
        .cpol(cpol), .cpha(cpha), .width(width),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .rx_overflow(rx_overflow), .tx_underflow(tx_underflow)
    );

    int          n_checks = 0, n_fail = 0;
    int          ovf_cnt = 0, unf_cnt = 0, beat_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mosi_words[4];
    logic [31:0] miso_words[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard on each accepted rx beat, count status pulses.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (rx_overflow)  ovf_cnt++;
            if (tx_underflow) unf_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%08h, expected no beat", m_axis_tdata);
                end else begin
                    check("rx_beat", m_axis_tdata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_tx(input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!s_axis_tready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_ready_timeout: got ready=0, expected ready=1");
        end else begin
            s_axis_tdata  = d;
            s_axis_tvalid = 1'b1;
            @(negedge clk);
            s_axis_tvalid = 1'b0;
        end
    endtask

    task automatic spi_frame(input int nw, input int w, input int abort_bits);
        int          wb, nbits;
        bit          stop;
        logic [31:0] rxw, txw;
        wb    = (w == 0 || w > 32) ? 32 : w;
        nbits = 0;
        stop  = 0;
        cs    = 1'b0;
        for (int k = 0; k < nw && !stop; k++) begin
            rxw = '0;
            txw = mosi_words[k];
            for (int b = wb - 1; b >= 0; b--) begin
                if (abort_bits != 0 && nbits == abort_bits) begin
                    stop = 1;
                    break;
                end
                if (!cpha) begin
                    mosi = txw[b];
                    half_period();
                    sck = ~cpol;
                    rxw[b] = miso;
                    half_period();
                    sck = cpol;
                end else begin
                    half_period();
                    sck  = ~cpol;
                    mosi = txw[b];
                    half_period();
                    sck = cpol;
                    rxw[b] = miso;
                end
                nbits++;
            end
            miso_words[k] = rxw;
        end
        half_period();
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic [5:0] w);
        cpol  = pol;
        cpha  = pha;
        sck   = pol;
        width = w;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_miso",      32'(miso),          32'd0);
        check("rst_tready",    32'(s_axis_tready), 32'd1);
        check("rst_tvalid",    32'(m_axis_tvalid), 32'd0);
        check("rst_tdata",     m_axis_tdata,       32'd0);
        check("rst_overflow",  32'(rx_overflow),   32'd0);
        check("rst_underflow", 32'(tx_underflow),  32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0, 8 bits
        set_mode(1'b0, 1'b0, 6'd8);
        send_tx(32'hA5);
        mosi_words[0] = 32'h3C;
        exp_q.push_back(32'h0000_003C);
        spi_frame(1, 8, 0);
        drain();
        check("m0_miso", miso_words[0], 32'hA5);

        // Mode 3, 16 bits
        set_mode(1'b1, 1'b1, 6'd16);
        send_tx(32'h1234);
        mosi_words[0] = 32'hBEEF;
        exp_q.push_back(32'h0000_BEEF);
        spi_frame(1, 16, 0);
        drain();
        check("m3_miso", miso_words[0], 32'h1234);

        // Two back-to-back words, tx refilled mid-frame
        set_mode(1'b0, 1'b0, 6'd8);
        send_tx(32'h11);
        fork send_tx(32'h22); join_none
        mosi_words[0] = 32'h5A;
        mosi_words[1] = 32'hC3;
        exp_q.push_back(32'h5A);
        exp_q.push_back(32'hC3);
        spi_frame(2, 8, 0);
        drain();
        check("b2b_miso0", miso_words[0], 32'h11);
        check("b2b_miso1", miso_words[1], 32'h22);
        check("b2b_underflows", 32'(unf_cnt), 32'd0);

        // Stalled sink: first word held, next two dropped
        m_axis_tready = 1'b0;
        send_tx(32'hF0);
        fork begin send_tx(32'h0F); send_tx(32'h99); end join_none
        mosi_words[0] = 32'h01;
        mosi_words[1] = 32'h02;
        mosi_words[2] = 32'h03;
        exp_q.push_back(32'h01);
        spi_frame(3, 8, 0);
        check("ovf_hold_valid", 32'(m_axis_tvalid), 32'd1);
        check("ovf_hold_data",  m_axis_tdata,       32'h01);
        check("ovf_pulses",     32'(ovf_cnt),       32'd2);
        check("ovf_miso2",      miso_words[2],      32'h99);
        m_axis_tready = 1'b1;
        drain();
        check("ovf_underflows", 32'(unf_cnt), 32'd0);

        // Abort after 5 of 8 bits, then a clean frame
        send_tx(32'h5A);
        mosi_words[0] = 32'hFF;
        spi_frame(1, 8, 5);
        check("abort_miso",    32'(miso),          32'd0);
        check("abort_beats",   32'(beat_cnt),      32'd5);
        check("abort_tvalid",  32'(m_axis_tvalid), 32'd0);
        check("abort_tready",  32'(s_axis_tready), 32'd1);
        check("abort_ovf",     32'(ovf_cnt),       32'd2);
        send_tx(32'hC3);
        mosi_words[0] = 32'h96;
        exp_q.push_back(32'h96);
        spi_frame(1, 8, 0);
        drain();
        check("post_abort_miso", miso_words[0], 32'hC3);

        // Empty tx buffer, 32-bit words; second frame uses width=0 (treated as 32)
        set_mode(1'b0, 1'b0, 6'd32);
        mosi_words[0] = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        spi_frame(1, 32, 0);
        drain();
        check("unf_miso", miso_words[0], 32'h0);
        check("unf_pulse", 32'(unf_cnt), 32'd1);
        set_mode(1'b0, 1'b0, 6'd0);
        mosi_words[0] = 32'h0BADF00D;
        exp_q.push_back(32'h0BADF00D);
        spi_frame(1, 0, 0);
        drain();
`ifdef SPI_SLAVE_ECHO_EN
        check("echo_miso", miso_words[0], 32'hDEADBEEF);
`else
        check("echo_miso", miso_words[0], 32'h0);
`endif
        check("unf_pulse2", 32'(unf_cnt), 32'd2);

        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave (target) endpoint: the far end of the SPI master link. It receives sck/cs/mosi from an external master and drives miso. Transmit words come from an AXI-Stream slave port; received words leave through an AXI-Stream master port. All SPI inputs are oversampled in the system clock domain, so no logic runs on sck.

Parameters:
sync_stages, 2, synchronizer depth on sck/cs/mosi (>=2)
max_width, 32, maximum word width in bits (fixed 32; datapath width)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cs  input  1  SPI chip select from master, active low
sck  input  1  SPI clock from master
mosi  input  1  master-out data
miso  output  1  slave-out data
cpol  input  1  idle sck level (0 = low, 1 = high)
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge
width  input  6  word width; 1..32 valid, 0 or >32 treated as 32; latched at cs fall
s_axis_tdata  input  32  tx word, right-aligned
s_axis_tvalid  input  1  tx word valid
s_axis_tready  output  1  tx holding buffer empty
m_axis_tdata  output  32  rx word, right-aligned, upper bits zero
m_axis_tvalid  output  1  rx word valid
m_axis_tready  input  1  downstream accept
rx_overflow  output  1  1-clk pulse: rx word dropped
tx_underflow  output  1  1-clk pulse: word started with empty tx buffer

Behaviour:
- Reset: miso=0, s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, rx_overflow=0, tx_underflow=0, FSM=IDLE, bit counter=0, tx buffer empty.
- Sync: sck, cs, mosi each pass through sync_stages FFs. Edges are detected on the synced sck only. Leading edge = transition away from cpol; trailing edge = transition back to cpol.
- Timing requirement: sck half-period >= 4 clk; cs setup to the first edge >= 4 clk.
- Tx buffer: one word. It loads on s_axis_tvalid & s_axis_tready; s_axis_tready then drops. It empties (ready=1 the next clk) when the word moves to the shift register.
- FSM IDLE: miso=0. On synced cs falling: latch width as W, go to LOAD.
- FSM LOAD (1 clk):
  - If the buffer is full, shift register = buffer[W-1:0].
  - Otherwise shift register = 0 and pulse tx_underflow.
  - Bit counter = 0. If cpha=0, drive miso = bit W-1 immediately. Go to SHIFT.
- FSM SHIFT, cpha=0: sample mosi on the leading edge; shift out the next bit on the trailing edge.
- FSM SHIFT, cpha=1: shift out on the leading edge (first leading edge presents bit W-1); sample on the trailing edge.
- Bit order: MSB first for both tx and rx.
- Word complete: when the sample count reaches W:
  - If m_axis_tvalid=0 or m_axis_tready=1 that cycle: m_axis_tdata = received bits zero-extended, m_axis_tvalid=1.
  - Otherwise the new word is dropped, the old word is held, and rx_overflow pulses.
  - Then return to LOAD for back-to-back words inside the same cs frame.
- m_axis_tvalid stays high until m_axis_tready. Data is stable while valid.
- Synced cs rising in any state: abort. Discard the partial rx word (no output, no overflow). A tx word already loaded is consumed, not restored. miso=0, go to IDLE. An incomplete word produces no m_axis beat.
- cs low with no sck edges: stay in SHIFT; no timeout.
- Reset mid-frame: all state clears asynchronously. After reset release, the block waits in IDLE for the next cs falling edge.
- A word occupying the whole frame is the normal case. Width changes take effect only at the next cs fall.

Optional Feature:
SPI_SLAVE_ECHO_EN.
- Defined: in LOAD with the tx buffer empty, the shift register loads the last completed rx word (reset value 0) instead of 0. tx_underflow still pulses.
- Undefined: an empty buffer transmits all zeros.
- Ports and all other behaviour are identical in both builds.

Test Plan:
- Mode 0 (cpol=0, cpha=0), width=8, tx 0xA5 preloaded, master sends 0x3C -> miso shows 1010_0101; m_axis_tdata=0x0000003C with valid=1; no pulses.
- Mode 3, width=16, tx 0x1234, master sends 0xBEEF -> master receives 0x1234; m_axis_tdata=0x0000BEEF.
- Two 8-bit words in one cs frame, tx 0x11 then 0x22 (refilled while the first shifts), m_axis_tready=1 -> two beats with correct data; no underflow.
- m_axis_tready=0, three 8-bit words 0x01, 0x02, 0x03 -> m_axis_tdata holds 0x01; rx_overflow pulses twice.
- cs raised after 5 of 8 bits -> no m_axis beat, miso=0, FSM IDLE. The next full frame is received correctly.
- Empty tx buffer, width=32, master sends 0xDEADBEEF -> miso all 0 and tx_underflow pulse. With SPI_SLAVE_ECHO_EN, a second frame echoes 0xDEADBEEF.
